// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants and types for the hazard/forwarding controller slice.
package hazard_fwd_ctrl_pkg;

  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int FORW_SEL_LEN      = 2;

  // Operand source chosen by the EXE-stage forwarding muxes
  typedef enum logic [FORW_SEL_LEN-1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle of the ID-stage request and the stall/flush/forwarding response.
interface hazard_fwd_ctrl_if
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
  parameter int CNT_W      = 32
) ();

  logic                    forward_en;
  logic                    mem_stall;
  logic                    id_valid;
  logic [REG_ADDR_W-1:0]   id_src1;
  logic [REG_ADDR_W-1:0]   id_src2;
  logic                    id_two_src;
  logic                    id_is_store;
  logic [REG_ADDR_W-1:0]   id_dest;
  logic                    id_wb_en;
  logic                    id_mem_read;
  logic                    br_taken;

  logic [FORW_SEL_LEN-1:0] val1_sel;
  logic [FORW_SEL_LEN-1:0] val2_sel;
  logic [FORW_SEL_LEN-1:0] st_val_sel;
  logic                    pc_freeze;
  logic                    if_id_freeze;
  logic                    id_exe_bubble;
  logic                    if_id_flush;
  logic [CNT_W-1:0]        stall_cycles;
  logic [CNT_W-1:0]        flush_count;

  modport master (
    output forward_en, mem_stall, id_valid, id_src1, id_src2, id_two_src,
           id_is_store, id_dest, id_wb_en, id_mem_read, br_taken,
    input  val1_sel, val2_sel, st_val_sel, pc_freeze, if_id_freeze,
           id_exe_bubble, if_id_flush, stall_cycles, flush_count
  );

  modport slave (
    input  forward_en, mem_stall, id_valid, id_src1, id_src2, id_two_src,
           id_is_store, id_dest, id_wb_en, id_mem_read, br_taken,
    output val1_sel, val2_sel, st_val_sel, pc_freeze, if_id_freeze,
           id_exe_bubble, if_id_flush, stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
// Picks the forwarding source for one EXE operand from the MEM and WB shadows.
module fwd_sel_unit
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_FILE_ADDR_LEN
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_en,
  input  logic                  i_memValid,
  input  logic [REG_ADDR_W-1:0] i_memDest,
  input  logic                  i_memWbEn,
  input  logic                  i_memMemRead,
  input  logic                  i_wbValid,
  input  logic [REG_ADDR_W-1:0] i_wbDest,
  input  logic                  i_wbWbEn,
  output fwd_sel_e              o_sel
);

  logic w_srcNonZero;
  logic w_memHit;
  logic w_wbHit;

  assign w_srcNonZero = (i_src != '0);
  assign w_memHit = i_memValid && i_memWbEn && (i_memDest == i_src) && w_srcNonZero;
  assign w_wbHit  = i_wbValid && i_wbWbEn && (i_wbDest == i_src) && w_srcNonZero;

  // MEM is the younger producer so it wins; a load in MEM has no result yet
  always_comb begin
    o_sel = FWD_REG;
    if (i_en) begin
      if (w_memHit && !i_memMemRead) begin
        o_sel = FWD_MEM;
      end else if (w_wbHit) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection, forwarding selects and stall/flush control for the 5-stage core.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);

  logic                  r_exeValid;
  logic [REG_ADDR_W-1:0] r_exeSrc1;
  logic [REG_ADDR_W-1:0] r_exeSrc2;
  logic                  r_exeTwoSrc;
  logic                  r_exeIsStore;
  logic [REG_ADDR_W-1:0] r_exeDest;
  logic                  r_exeWbEn;
  logic                  r_exeMemRead;

  logic                  r_memValid;
  logic [REG_ADDR_W-1:0] r_memDest;
  logic                  r_memWbEn;
  logic                  r_memMemRead;

  logic                  r_wbValid;
  logic [REG_ADDR_W-1:0] r_wbDest;
  logic                  r_wbWbEn;

  logic [CNT_W-1:0]      r_stallCycles;
  logic [CNT_W-1:0]      r_flushCount;

  logic     w_fwdActive;
  fwd_sel_e w_val1Sel;
  fwd_sel_e w_val2Sel;
  fwd_sel_e w_stValSel;

  logic w_useSrc2;
  logic w_src1Exe;
  logic w_src2Exe;
  logic w_src1Mem;
  logic w_src2Mem;
  logic w_hz;
  logic w_flush;

  assign w_fwdActive = bus.forward_en && r_exeValid;

  fwd_sel_unit #(.REG_ADDR_W(REG_ADDR_W)) u_val1Sel (
    .i_src(r_exeSrc1), .i_en(w_fwdActive),
    .i_memValid(r_memValid), .i_memDest(r_memDest), .i_memWbEn(r_memWbEn),
    .i_memMemRead(r_memMemRead),
    .i_wbValid(r_wbValid), .i_wbDest(r_wbDest), .i_wbWbEn(r_wbWbEn),
    .o_sel(w_val1Sel)
  );

  fwd_sel_unit #(.REG_ADDR_W(REG_ADDR_W)) u_val2Sel (
    .i_src(r_exeSrc2), .i_en(w_fwdActive && r_exeTwoSrc),
    .i_memValid(r_memValid), .i_memDest(r_memDest), .i_memWbEn(r_memWbEn),
    .i_memMemRead(r_memMemRead),
    .i_wbValid(r_wbValid), .i_wbDest(r_wbDest), .i_wbWbEn(r_wbWbEn),
    .o_sel(w_val2Sel)
  );

  fwd_sel_unit #(.REG_ADDR_W(REG_ADDR_W)) u_stValSel (
    .i_src(r_exeSrc2), .i_en(w_fwdActive && r_exeIsStore),
    .i_memValid(r_memValid), .i_memDest(r_memDest), .i_memWbEn(r_memWbEn),
    .i_memMemRead(r_memMemRead),
    .i_wbValid(r_wbValid), .i_wbDest(r_wbDest), .i_wbWbEn(r_wbWbEn),
    .o_sel(w_stValSel)
  );

  // Producer matches for the ID sources; r0 never creates a dependence
  assign w_useSrc2 = bus.id_two_src || bus.id_is_store;
  assign w_src1Exe = r_exeValid && r_exeWbEn && (r_exeDest == bus.id_src1) && (bus.id_src1 != '0);
  assign w_src2Exe = r_exeValid && r_exeWbEn && (r_exeDest == bus.id_src2) && (bus.id_src2 != '0);
  assign w_src1Mem = r_memValid && r_memWbEn && (r_memDest == bus.id_src1) && (bus.id_src1 != '0);
  assign w_src2Mem = r_memValid && r_memWbEn && (r_memDest == bus.id_src2) && (bus.id_src2 != '0);

  // Load-use with forwarding; any EXE/MEM producer without it (WB is write-before-read)
  always_comb begin
    w_hz = 1'b0;
    if (bus.id_valid) begin
      if (bus.forward_en) begin
        w_hz = r_exeMemRead && (w_src1Exe || (w_useSrc2 && w_src2Exe));
      end else begin
        w_hz = w_src1Exe || w_src1Mem || (w_useSrc2 && (w_src2Exe || w_src2Mem));
      end
    end
  end

  assign w_flush = bus.br_taken && !w_hz && !bus.mem_stall;

  assign bus.val1_sel      = w_val1Sel;
  assign bus.val2_sel      = w_val2Sel;
  assign bus.st_val_sel    = w_stValSel;
  assign bus.pc_freeze     = bus.mem_stall || w_hz;
  assign bus.if_id_freeze  = bus.mem_stall || w_hz;
  assign bus.id_exe_bubble = w_hz && !bus.mem_stall;
  assign bus.if_id_flush   = w_flush;
  assign bus.stall_cycles  = r_stallCycles;
  assign bus.flush_count   = r_flushCount;

  // Shadow pipeline advances with the core and freezes during a memory wait
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exeValid   <= 1'b0;
      r_exeSrc1    <= '0;
      r_exeSrc2    <= '0;
      r_exeTwoSrc  <= 1'b0;
      r_exeIsStore <= 1'b0;
      r_exeDest    <= '0;
      r_exeWbEn    <= 1'b0;
      r_exeMemRead <= 1'b0;
      r_memValid   <= 1'b0;
      r_memDest    <= '0;
      r_memWbEn    <= 1'b0;
      r_memMemRead <= 1'b0;
      r_wbValid    <= 1'b0;
      r_wbDest     <= '0;
      r_wbWbEn     <= 1'b0;
    end else if (!bus.mem_stall) begin
      r_wbValid    <= r_memValid;
      r_wbDest     <= r_memDest;
      r_wbWbEn     <= r_memWbEn;
      r_memValid   <= r_exeValid;
      r_memDest    <= r_exeDest;
      r_memWbEn    <= r_exeWbEn;
      r_memMemRead <= r_exeMemRead;
      r_exeValid   <= bus.id_valid && !w_hz;
      r_exeSrc1    <= bus.id_src1;
      r_exeSrc2    <= bus.id_src2;
      r_exeTwoSrc  <= bus.id_two_src;
      r_exeIsStore <= bus.id_is_store;
      r_exeDest    <= bus.id_dest;
      r_exeWbEn    <= bus.id_wb_en;
      r_exeMemRead <= bus.id_mem_read;
    end
  end

  // Saturating counts of hazard-stall cycles and IF/ID flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      if (w_hz && !bus.mem_stall && (r_stallCycles != '1)) begin
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
      if (w_flush && (r_flushCount != '1)) begin
        r_flushCount <= r_flushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scoreboard bench for the hazard/forwarding controller.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  typedef struct {
    logic       valid;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       twoSrc;
    logic       isStore;
    logic [4:0] dest;
    logic       wbEn;
    logic       memRead;
  } instr_t;

  typedef struct {
    string      tag;
    logic [1:0] v1;
    logic [1:0] v2;
    logic [1:0] st;
    logic       frz;
    logic       bub;
    logic       fl;
    int         sc;
    int         fc;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t expQ[$];

  hazard_fwd_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t nop();
    instr_t r = '{default: '0};
    return r;
  endfunction

  function automatic instr_t alu(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    instr_t r = '{default: '0};
    r.valid = 1'b1; r.src1 = s1; r.src2 = s2; r.twoSrc = 1'b1; r.dest = d; r.wbEn = 1'b1;
    return r;
  endfunction

  function automatic instr_t load(input logic [4:0] d, input logic [4:0] base);
    instr_t r = '{default: '0};
    r.valid = 1'b1; r.src1 = base; r.dest = d; r.wbEn = 1'b1; r.memRead = 1'b1;
    return r;
  endfunction

  function automatic instr_t store(input logic [4:0] data, input logic [4:0] base);
    instr_t r = '{default: '0};
    r.valid = 1'b1; r.src1 = base; r.src2 = data; r.isStore = 1'b1;
    return r;
  endfunction

  function automatic instr_t branch(input logic [4:0] s1, input logic [4:0] s2);
    instr_t r = '{default: '0};
    r.valid = 1'b1; r.src1 = s1; r.src2 = s2; r.twoSrc = 1'b1;
    return r;
  endfunction

  function automatic exp_t mkExp(input string tag, input logic [1:0] v1, input logic [1:0] v2,
                                 input logic [1:0] st, input logic frz, input logic bub,
                                 input logic fl, input int sc, input int fc);
    exp_t e;
    e.tag = tag; e.v1 = v1; e.v2 = v2; e.st = st;
    e.frz = frz; e.bub = bub; e.fl = fl; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic checkField(input string tag, input string name, input logic [31:0] obs,
                            input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard empty");
    end else begin
      e = expQ.pop_front();
      checkField(e.tag, "val1_sel",      32'(bus.val1_sel),      32'(e.v1));
      checkField(e.tag, "val2_sel",      32'(bus.val2_sel),      32'(e.v2));
      checkField(e.tag, "st_val_sel",    32'(bus.st_val_sel),    32'(e.st));
      checkField(e.tag, "pc_freeze",     32'(bus.pc_freeze),     32'(e.frz));
      checkField(e.tag, "if_id_freeze",  32'(bus.if_id_freeze),  32'(e.frz));
      checkField(e.tag, "id_exe_bubble", 32'(bus.id_exe_bubble), 32'(e.bub));
      checkField(e.tag, "if_id_flush",   32'(bus.if_id_flush),   32'(e.fl));
      checkField(e.tag, "stall_cycles",  bus.stall_cycles,       32'(e.sc));
      checkField(e.tag, "flush_count",   bus.flush_count,        32'(e.fc));
    end
  endtask

  task automatic drive(input instr_t ins, input logic br, input logic fwd,
                       input logic ms, input logic rs);
    rst             = rs;
    bus.forward_en  = fwd;
    bus.mem_stall   = ms;
    bus.br_taken    = br;
    bus.id_valid    = ins.valid;
    bus.id_src1     = ins.src1;
    bus.id_src2     = ins.src2;
    bus.id_two_src  = ins.twoSrc;
    bus.id_is_store = ins.isStore;
    bus.id_dest     = ins.dest;
    bus.id_wb_en    = ins.wbEn;
    bus.id_mem_read = ins.memRead;
  endtask

  task automatic applyStimulus(input instr_t ins, input logic br, input logic fwd,
                               input logic ms, input logic rs, input exp_t e);
    drive(ins, br, fwd, ms, rs);
    expQ.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence; ID inputs are held by the bench while the DUT freezes IF/ID
  initial begin
    instr_t lx;
    checks   = 0;
    failures = 0;
    drive(nop(), 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    applyStimulus(nop(), 0, 1, 0, 1, mkExp("reset", 0, 0, 0, 0, 0, 0, 0, 0));

    // Back-to-back dependence forwarded from MEM
    applyStimulus(alu(1, 6, 7), 0, 1, 0, 0, mkExp("A1", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(alu(2, 1, 5), 0, 1, 0, 0, mkExp("A2", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("A3", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("A4", 0, 0, 0, 0, 0, 0, 0, 0));

    // MEM over WB, then WB alone
    applyStimulus(alu(1, 6, 7), 0, 1, 0, 0, mkExp("B1", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(alu(1, 6, 7), 0, 1, 0, 0, mkExp("B2", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(alu(3, 1, 1), 0, 1, 0, 0, mkExp("B3", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("B4", 1, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(alu(1, 6, 7), 0, 1, 0, 0, mkExp("B5", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("B6", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(alu(3, 1, 1), 0, 1, 0, 0, mkExp("B7", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("B8", 2, 2, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("B9", 0, 0, 0, 0, 0, 0, 0, 0));

    // Load-use into store data
    applyStimulus(load(3, 4),   0, 1, 0, 0, mkExp("C1", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(store(3, 4),  0, 1, 0, 0, mkExp("C2", 0, 0, 0, 1, 1, 0, 0, 0));
    applyStimulus(store(3, 4),  0, 1, 0, 0, mkExp("C3", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("C4", 0, 0, 2, 0, 0, 0, 1, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("C5", 0, 0, 0, 0, 0, 0, 1, 0));

    // r0 never forwards or stalls; invalid instructions are ignored
    lx = load(5, 6);
    lx.valid = 1'b0;
    applyStimulus(alu(0, 6, 7), 0, 1, 0, 0, mkExp("D1", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(alu(2, 0, 0), 0, 1, 0, 0, mkExp("D2", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(lx,           0, 1, 0, 0, mkExp("D3", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(alu(8, 5, 5), 0, 1, 0, 0, mkExp("D4", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(load(0, 6),   0, 1, 0, 0, mkExp("D5", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(alu(7, 0, 0), 0, 1, 0, 0, mkExp("D6", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("D7", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("D8", 0, 0, 0, 0, 0, 0, 1, 0));

    // No forwarding: adjacent dependence stalls two cycles
    applyStimulus(alu(1, 6, 7), 0, 0, 0, 0, mkExp("E1", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(alu(2, 1, 5), 0, 0, 0, 0, mkExp("E2", 0, 0, 0, 1, 1, 0, 1, 0));
    applyStimulus(alu(2, 1, 5), 0, 0, 0, 0, mkExp("E3", 0, 0, 0, 1, 1, 0, 2, 0));
    applyStimulus(alu(2, 1, 5), 0, 0, 0, 0, mkExp("E4", 0, 0, 0, 0, 0, 0, 3, 0));
    applyStimulus(nop(),        0, 0, 0, 0, mkExp("E5", 0, 0, 0, 0, 0, 0, 3, 0));
    applyStimulus(nop(),        0, 0, 0, 0, mkExp("E6", 0, 0, 0, 0, 0, 0, 3, 0));

    // Taken branch behind a stall flushes only once the stall clears
    applyStimulus(alu(1, 6, 7), 0, 0, 0, 0, mkExp("F1", 0, 0, 0, 0, 0, 0, 3, 0));
    applyStimulus(branch(1, 5), 1, 0, 0, 0, mkExp("F2", 0, 0, 0, 1, 1, 0, 3, 0));
    applyStimulus(branch(1, 5), 1, 0, 0, 0, mkExp("F3", 0, 0, 0, 1, 1, 0, 4, 0));
    applyStimulus(branch(1, 5), 1, 0, 0, 0, mkExp("F4", 0, 0, 0, 0, 0, 1, 5, 0));
    applyStimulus(nop(),        0, 0, 0, 0, mkExp("F5", 0, 0, 0, 0, 0, 0, 5, 1));
    applyStimulus(nop(),        0, 0, 0, 0, mkExp("F6", 0, 0, 0, 0, 0, 0, 5, 1));

    // Memory wait over a load-use hazard, then reset mid-stall
    applyStimulus(load(3, 4),   0, 1, 0, 0, mkExp("G1", 0, 0, 0, 0, 0, 0, 5, 1));
    applyStimulus(alu(9, 3, 6), 0, 1, 1, 0, mkExp("G2", 0, 0, 0, 1, 0, 0, 5, 1));
    applyStimulus(alu(9, 3, 6), 0, 1, 1, 0, mkExp("G3", 0, 0, 0, 1, 0, 0, 5, 1));
    applyStimulus(alu(9, 3, 6), 0, 1, 1, 0, mkExp("G4", 0, 0, 0, 1, 0, 0, 5, 1));
    applyStimulus(alu(9, 3, 6), 0, 1, 0, 1, mkExp("G5", 0, 0, 0, 1, 1, 0, 5, 1));
    applyStimulus(alu(9, 3, 6), 0, 1, 0, 0, mkExp("G6", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("G7", 0, 0, 0, 0, 0, 0, 0, 0));

    // Memory wait masks a taken branch
    applyStimulus(branch(6, 7), 1, 1, 1, 0, mkExp("H1", 0, 0, 0, 1, 0, 0, 0, 0));
    applyStimulus(branch(6, 7), 1, 1, 0, 0, mkExp("H2", 0, 0, 0, 0, 0, 1, 0, 0));
    applyStimulus(nop(),        0, 1, 0, 0, mkExp("H3", 0, 0, 0, 0, 0, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
